sparse_core_ctrl: RTL

Sequencing controller for the 4-row `sparse_core` PE array. On a start command it clears the PE accumulators and streams `k_len` weight/activation addresses from base addresses into the weight and activation buffers. It enables the core in step with the buffers' 1-cycle read latency, waits for the PE pipeline to settle, and captures the four 20-bit column sums into a result register. The result is offered on a valid/ready port. The block sits between the host command interface and the `sparse_core` + buffer pair.

---
 rtl/sparse_pkg.sv | 18 +
 rtl/sparse_core_ctrl_if.sv | 42 ++++
 rtl/sparse_core_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sparse_pkg.sv
// Shared types and constants for the sparse_core PE array and its sequencing controller.
package sparse_pkg;

    localparam int PSUM_W = 20;
    localparam int NUM_PE = 4;

    // One partial sum per PE row; signed so sign survives capture and transport.
    typedef logic signed [PSUM_W-1:0] psum_vec_t [0:NUM_PE-1];

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        OUTPUT
    } ctrl_state_t;

endpackage

// File: rtl/sparse_core_ctrl_if.sv
// Bundle of the host command port, buffer/core sequencing port and result port
// of sparse_core_ctrl. The controller takes the slave view, the host side the master view.
interface sparse_core_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int K_W    = 8
);
    import sparse_pkg::*;

    // Host command
    logic              start;
    logic [K_W-1:0]    k_len;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] a_base;
    logic              busy;
    logic              done;

    // Buffer and core control
    logic              buf_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] a_rd_addr;
    logic              core_en;
    logic              core_clr;
    psum_vec_t         psum_in;

    // Result port
    logic              res_valid;
    logic              res_ready;
    psum_vec_t         res_data;

    modport slave (
        input  start, k_len, w_base, a_base, psum_in, res_ready,
        output busy, done, buf_rd_en, w_rd_addr, a_rd_addr,
               core_en, core_clr, res_valid, res_data
    );

    modport master (
        output start, k_len, w_base, a_base, psum_in, res_ready,
        input  busy, done, buf_rd_en, w_rd_addr, a_rd_addr,
               core_en, core_clr, res_valid, res_data
    );

endinterface

// File: rtl/sparse_core_ctrl.sv
// Sequencing controller for the 4-row sparse_core: clears accumulators, streams
// buffer addresses, enables the core one cycle behind the buffer reads, waits for
// the PE pipeline and hands the captured column sums out on a valid/ready port.
module sparse_core_ctrl
    import sparse_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int K_W    = 8,
    parameter int PE_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    sparse_core_ctrl_if.slave  bus
);

    localparam int DRAIN_W = $clog2(PE_LAT + 2);

    ctrl_state_t       state_q, state_d;
    logic [K_W-1:0]    k_len_q;
    logic [K_W-1:0]    step_q, step_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [ADDR_W-1:0] w_base_q, a_base_q;
    logic              core_en_q;
    logic              zero_done_q;

    logic accept_cmd;
    logic accept_zero;
    logic last_step;
    logic last_drain;
    logic capture;
    logic handshake;
    logic fetching;

    assign accept_cmd  = (state_q == IDLE) && bus.start && (bus.k_len != '0);
    assign accept_zero = (state_q == IDLE) && bus.start && (bus.k_len == '0);
    assign last_step   = (step_q == k_len_q - K_W'(1));
    assign last_drain  = (drain_q == DRAIN_W'(PE_LAT));
    assign capture     = (state_q == DRAIN) && last_drain;
    assign handshake   = (state_q == OUTPUT) && bus.res_ready;
    assign fetching    = (state_q == FETCH);

    // Next-state, step counter and drain counter logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                step_d  = '0;
                drain_d = '0;
                if (accept_cmd) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FETCH;
                step_d  = '0;
            end
            FETCH: begin
                if (last_step) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    step_d = step_q + K_W'(1);
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    state_d = OUTPUT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            OUTPUT: begin
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched command and the core_en delay stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            drain_q     <= '0;
            k_len_q     <= '0;
            w_base_q    <= '0;
            a_base_q    <= '0;
            core_en_q   <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            drain_q     <= drain_d;
            core_en_q   <= fetching;
            zero_done_q <= accept_zero;
            if (accept_cmd) begin
                k_len_q  <= bus.k_len;
                w_base_q <= bus.w_base;
                a_base_q <= bus.a_base;
            end
        end
    end

    // Per-lane result register: loads the core sums at the end of DRAIN, holds otherwise.
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_res
        logic signed [PSUM_W-1:0] res_q;

        // Capture this lane's column sum; only reset clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                res_q <= '0;
            end else if (capture) begin
                res_q <= bus.psum_in[gi];
            end
        end

        assign bus.res_data[gi] = res_q;
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = zero_done_q | handshake;
    assign bus.buf_rd_en = fetching;
    // Addresses are only meaningful while fetching; parked at zero otherwise.
    assign bus.w_rd_addr = fetching ? (w_base_q + ADDR_W'(step_q)) : '0;
    assign bus.a_rd_addr = fetching ? (a_base_q + ADDR_W'(step_q)) : '0;
    assign bus.core_en   = core_en_q;
    assign bus.core_clr  = (state_q == CLEAR);
    assign bus.res_valid = (state_q == OUTPUT);

endmodule
